// File: rtl/sipo_deser.sv
// Lane-serial to frame-parallel deserializer with a one-frame valid/ready holding
// register, resync, sticky overflow flag and a delivered-frame counter.
module sipo_deser #(
    parameter int DATA_WID   = 8,
    parameter int MEMORY_WID = 4,
    parameter int LANE_WID   = 1,
    parameter int LSB_FIRST  = 1,
    parameter int CNT_WID    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [LANE_WID-1:0]            in_data,
    input  logic                           sync,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WID*MEMORY_WID-1:0] out_data,
    output logic                           ovf,
    input  logic                           ovf_clr,
    output logic [CNT_WID-1:0]             frame_cnt
);

    localparam int FRAME_W = DATA_WID * MEMORY_WID;
    localparam int SLOTS   = DATA_WID / LANE_WID;
    localparam int BEATS   = FRAME_W / LANE_WID;
    localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    // Bit offset inside the frame where beat b lands.
    function automatic int slot_base(input int b);
        int w;
        int s;
        w = b / SLOTS;
        s = b % SLOTS;
        if (LSB_FIRST != 0)
            return w * DATA_WID + s * LANE_WID;
        return w * DATA_WID + DATA_WID - (s + 1) * LANE_WID;
    endfunction

    logic [IDX_W-1:0]   r_beat_idx;
    logic [FRAME_W-1:0] r_asm_p0;
    logic [FRAME_W-1:0] r_out_data_p1;
    logic               r_vld_p1;
    logic               r_ovf;
    logic [CNT_WID-1:0] r_frame_cnt;

    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [FRAME_W-1:0] w_asm;
    logic               w_last;
    logic               w_free;
    logic               w_load;
    logic               w_drop;

    // Stage p0: beat placement into the assembly register
    always_comb begin
        w_idx = sync ? '0 : r_beat_idx;
        w_asm = r_asm_p0;
        for (int b = 0; b < BEATS; b++) begin
            if (in_valid && (w_idx == IDX_W'(b)))
                w_asm[slot_base(b) +: LANE_WID] = in_data;
        end
        w_last = in_valid && (w_idx == LAST_IDX);
        if (!in_valid)
            w_idx_nxt = w_idx;
        else if (w_last)
            w_idx_nxt = '0;
        else
            w_idx_nxt = w_idx + IDX_W'(1);
        w_free = !r_vld_p1 || out_ready;
        w_load = w_last && w_free;
        w_drop = w_last && !w_free;
    end

    // Stage p1: holding register and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_idx    <= '0;
            r_asm_p0      <= '0;
            r_out_data_p1 <= '0;
            r_vld_p1      <= 1'b0;
            r_ovf         <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_beat_idx <= w_idx_nxt;
            r_asm_p0   <= w_asm;
            if (w_load) begin
                r_out_data_p1 <= w_asm;
                r_vld_p1      <= 1'b1;
                r_frame_cnt   <= r_frame_cnt + CNT_WID'(1);
            end else if (r_vld_p1 && out_ready) begin
                r_vld_p1 <= 1'b0;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign out_valid = r_vld_p1;
    assign out_data  = r_out_data_p1;
    assign ovf       = r_ovf;
    assign frame_cnt = r_frame_cnt;

endmodule
